// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and bit-period computation.
// Used by both the receiver and the transmitter.
`timescale 1ns/1ps
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4,
      S_PARITY    = 3'd5
   } state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to RESET_VAL.
`timescale 1ns/1ps
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and registered valid/frame_err strobes.
// Define UART_RX_PARITY_EN for 8E1 operation (even parity bit between data and stop).
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clock_50M,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       IDX_LAST     = 3'(DATA_BITS - 1);

   state_t                 state, next_state;
   logic                   rx_s;
   logic [CNT_W-1:0]       clk_cnt;
   logic [2:0]             bit_idx;
   logic [DATA_BITS-1:0]   shift_reg;
   logic                   bit_end, cnt_clr, sample, ok_set, err_set;
   logic                   ok_p0, err_p0;
   logic                   par_bad;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk (clock_50M),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   assign bit_end = (clk_cnt == BIT_LAST);
   assign cnt_clr = (next_state != state) || bit_end;

   always_comb begin
      next_state = state;
      sample     = 1'b0;
      ok_set     = 1'b0;
      err_set    = 1'b0;
      case (state)
         S_IDLE: if (!rx_s) next_state = S_START;
         S_START: begin
            // A start bit that has gone high again by mid-bit is treated as noise.
            if (clk_cnt == HALF_LAST) next_state = rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (bit_end) begin
               sample = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (bit_idx == IDX_LAST) next_state = S_PARITY;
`else
               if (bit_idx == IDX_LAST) next_state = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (bit_end) next_state = S_STOP;
`endif
         S_STOP: begin
            if (bit_end) begin
               if (rx_s && !par_bad) begin
                  ok_set     = 1'b1;
                  next_state = S_IDLE;
               end else begin
                  err_set    = 1'b1;
                  next_state = rx_s ? S_IDLE : S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: if (rx_s) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_50M or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         ok_p0     <= 1'b0;
         err_p0    <= 1'b0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
         rx_data   <= '0;
      end else begin
         state   <= next_state;
         clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
         if (state == S_IDLE) bit_idx <= '0;
         else if (sample)     bit_idx <= bit_idx + 1'b1;
         if (sample) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
         // Output stage: strobes and busy are registered one cycle after the decision.
         ok_p0     <= ok_set;
         err_p0    <= err_set;
         valid     <= ok_p0;
         frame_err <= err_p0;
         busy      <= (state != S_IDLE);
         if (ok_p0) rx_data <= shift_reg;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clock_50M or posedge rst) begin
      if (rst)                             par_bad <= 1'b0;
      else if (state == S_PARITY && bit_end) par_bad <= ^{shift_reg, rx_s};
   end
`else
   assign par_bad = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at N = 10 clocks per bit: directed scenarios plus randomized frames vs. a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CLK_FREQ  = 50_000_000;
   localparam int BAUD_RATE = 5_000_000;
   localparam int N = CLK_FREQ / BAUD_RATE;
   localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
   localparam int EXTRA = N;
`else
   localparam int EXTRA = 0;
`endif
   localparam int LAT   = 3 + H + 9 * N + EXTRA;
   localparam int FRAME = 10 * N + EXTRA;

   logic       clk = 1'b0, rst = 1'b1, rx = 1'b1;
   logic [7:0] rx_data;
   logic       valid, frame_err, busy;

   int         cyc = 0;
   int         pass_cnt = 0, check_cnt = 0;
   int         vcyc[$];
   logic [7:0] vdat[$];
   int         ecyc[$];
   int         brise[$];
   int         busy_cnt = 0, both_cnt = 0;
   logic       busy_prev = 1'b0;
   logic [7:0] model_data = 8'h00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
      .clock_50M (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always @(negedge clk) begin
      if (valid) begin
         vcyc.push_back(cyc);
         vdat.push_back(rx_data);
      end
      if (frame_err) ecyc.push_back(cyc);
      if (valid && frame_err) both_cnt++;
      if (busy && !busy_prev) brise.push_back(cyc);
      if (busy) busy_cnt++;
      busy_prev = busy;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, check_cnt);
      $fatal(1);
   end

   task automatic clear_mon();
      vcyc.delete();
      vdat.delete();
      ecyc.delete();
      brise.delete();
      busy_cnt = 0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Caller must be #1 after a rising edge; the next edge is edge 0 of the frame.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                             output int c0);
      logic p;
      p  = par_bit;
      c0 = cyc + 1;
      rx = 1'b0;
      wait_cyc(N);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_cyc(N);
      end
`ifdef UART_RX_PARITY_EN
      rx = p;
      wait_cyc(N);
`endif
      rx = stop_bit;
      wait_cyc(N);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_cyc(3);
      check_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else pass_cnt++;
      check_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else pass_cnt++;
      check_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      rst = 1'b0;
      wait_cyc(10);
      check_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
      model_data = 8'h00;
   endtask

   task automatic test_single_frame();
      int c0;
      clear_mon();
      send_frame(8'h37, 1'b1, ^8'h37, c0);
      wait_cyc(20);
      check_cnt++; if (vcyc.size() !== 1) $display("FAIL single_valid_count: got %0d want 1", vcyc.size()); else pass_cnt++;
      if (vcyc.size() >= 1) begin
         check_cnt++; if (vdat[0] !== 8'h37) $display("FAIL single_data: got %h want 37", vdat[0]); else pass_cnt++;
         check_cnt++; if (vcyc[0] !== c0 + LAT) $display("FAIL single_valid_edge: got %0d want %0d", vcyc[0] - c0, LAT); else pass_cnt++;
      end
      check_cnt++; if (ecyc.size() !== 0) $display("FAIL single_frame_err: got %0d pulses want 0", ecyc.size()); else pass_cnt++;
      check_cnt++; if (brise.size() < 1 || brise[0] !== c0 + 3)
         $display("FAIL busy_rise_edge: got %0d want %0d", (brise.size() > 0) ? brise[0] - c0 : -1, 3); else pass_cnt++;
      check_cnt++; if (rx_data !== 8'h37) $display("FAIL single_hold: got %h want 37", rx_data); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy); else pass_cnt++;
      model_data = 8'h37;
   endtask

   task automatic test_back_to_back();
      int c0, c1;
      clear_mon();
      send_frame(8'hCC, 1'b1, ^8'hCC, c0);
      send_frame(8'h55, 1'b1, ^8'h55, c1);
      wait_cyc(20);
      check_cnt++; if (vcyc.size() !== 2) $display("FAIL b2b_count: got %0d want 2", vcyc.size()); else pass_cnt++;
      if (vcyc.size() >= 2) begin
         check_cnt++; if (vdat[0] !== 8'hCC) $display("FAIL b2b_first: got %h want cc", vdat[0]); else pass_cnt++;
         check_cnt++; if (vdat[1] !== 8'h55) $display("FAIL b2b_second: got %h want 55", vdat[1]); else pass_cnt++;
         check_cnt++; if (vcyc[1] - vcyc[0] !== FRAME) $display("FAIL b2b_spacing: got %0d want %0d", vcyc[1] - vcyc[0], FRAME); else pass_cnt++;
         check_cnt++; if (vcyc[1] !== c1 + LAT) $display("FAIL b2b_second_edge: got %0d want %0d", vcyc[1] - c1, LAT); else pass_cnt++;
      end
      check_cnt++; if (ecyc.size() !== 0) $display("FAIL b2b_frame_err: got %0d want 0", ecyc.size()); else pass_cnt++;
      model_data = 8'h55;
   endtask

   task automatic test_glitch();
      clear_mon();
      rx = 1'b0;
      wait_cyc(3);
      rx = 1'b1;
      wait_cyc(40);
      check_cnt++; if (vcyc.size() !== 0) $display("FAIL glitch_valid: got %0d pulses want 0", vcyc.size()); else pass_cnt++;
      check_cnt++; if (ecyc.size() !== 0) $display("FAIL glitch_frame_err: got %0d pulses want 0", ecyc.size()); else pass_cnt++;
      check_cnt++; if (busy_cnt > H) $display("FAIL glitch_busy_len: got %0d cycles want <= %0d", busy_cnt, H); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy_end: got %b want 0", busy); else pass_cnt++;
      check_cnt++; if (rx_data !== model_data) $display("FAIL glitch_hold: got %h want %h", rx_data, model_data); else pass_cnt++;
   endtask

   task automatic test_frame_error();
      int c0;
      logic [7:0] d;
      clear_mon();
      send_frame(8'hA5, 1'b0, ^8'hA5, c0);
      wait_cyc(50);
      check_cnt++; if (ecyc.size() !== 1) $display("FAIL ferr_count: got %0d want 1", ecyc.size()); else pass_cnt++;
      if (ecyc.size() >= 1) begin
         check_cnt++; if (ecyc[0] !== c0 + LAT) $display("FAIL ferr_edge: got %0d want %0d", ecyc[0] - c0, LAT); else pass_cnt++;
      end
      check_cnt++; if (vcyc.size() !== 0) $display("FAIL ferr_valid: got %0d want 0", vcyc.size()); else pass_cnt++;
      check_cnt++; if (rx_data !== model_data) $display("FAIL ferr_hold: got %h want %h", rx_data, model_data); else pass_cnt++;
      check_cnt++; if (busy !== 1'b1) $display("FAIL ferr_busy_break: got %b want 1", busy); else pass_cnt++;
      rx = 1'b1;
      wait_cyc(10);
      check_cnt++; if (busy !== 1'b0) $display("FAIL ferr_busy_release: got %b want 0", busy); else pass_cnt++;
      check_cnt++; if (ecyc.size() !== 1 || vcyc.size() !== 0)
         $display("FAIL ferr_phantom: got %0d err %0d valid want 1 and 0", ecyc.size(), vcyc.size()); else pass_cnt++;
      clear_mon();
      d = 8'($urandom);
      send_frame(d, 1'b1, ^d, c0);
      wait_cyc(20);
      check_cnt++; if (vcyc.size() !== 1 || vdat[0] !== d)
         $display("FAIL ferr_recover: got %0d pulses data %h want 1 pulse data %h", vcyc.size(), rx_data, d); else pass_cnt++;
      model_data = d;
   endtask

   task automatic test_reset_mid_frame();
      int c0;
      clear_mon();
      rx = 1'b0;
      wait_cyc(N);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         wait_cyc(N);
      end
      rst = 1'b1;
      rx  = 1'b1;
      #2;
      check_cnt++; if (rx_data !== 8'h00) $display("FAIL midrst_rx_data: got %h want 00", rx_data); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
      check_cnt++; if (valid !== 1'b0 || frame_err !== 1'b0)
         $display("FAIL midrst_strobes: got valid %b frame_err %b want 0 0", valid, frame_err); else pass_cnt++;
      @(posedge clk);
      #1;
      wait_cyc(2);
      rst = 1'b0;
      model_data = 8'h00;
      wait_cyc(20);
      check_cnt++; if (vcyc.size() !== 0 || ecyc.size() !== 0)
         $display("FAIL midrst_pulse: got %0d valid %0d err want 0 0", vcyc.size(), ecyc.size()); else pass_cnt++;
      send_frame(8'h01, 1'b1, ^8'h01, c0);
      wait_cyc(20);
      check_cnt++; if (vcyc.size() !== 1 || rx_data !== 8'h01)
         $display("FAIL midrst_next: got %0d pulses data %h want 1 pulse data 01", vcyc.size(), rx_data); else pass_cnt++;
      model_data = 8'h01;
   endtask

   task automatic test_random();
      int         exp_vcyc[$];
      logic [7:0] exp_vdat[$];
      int         exp_ecyc[$];
      logic [7:0] d;
      logic       stop_bit, par_bit, good;
      int         c0, n;
      clear_mon();
      for (int k = 0; k < 16; k++) begin
         d        = 8'($urandom);
         stop_bit = ($urandom_range(0, 3) != 0);
         par_bit  = ^d;
`ifdef UART_RX_PARITY_EN
         if ($urandom_range(0, 4) == 0) par_bit = ~par_bit;
`endif
         send_frame(d, stop_bit, par_bit, c0);
         good = stop_bit && ((^{d, par_bit}) == 1'b0 || EXTRA == 0);
         if (good) begin
            exp_vcyc.push_back(c0 + LAT);
            exp_vdat.push_back(d);
            model_data = d;
         end else begin
            exp_ecyc.push_back(c0 + LAT);
         end
         rx = 1'b1;
         wait_cyc(stop_bit ? $urandom_range(0, 20) : $urandom_range(5, 30));
      end
      wait_cyc(30);
      check_cnt++; if (vcyc.size() !== exp_vcyc.size())
         $display("FAIL rand_valid_count: got %0d want %0d", vcyc.size(), exp_vcyc.size()); else pass_cnt++;
      check_cnt++; if (ecyc.size() !== exp_ecyc.size())
         $display("FAIL rand_err_count: got %0d want %0d", ecyc.size(), exp_ecyc.size()); else pass_cnt++;
      n = (vcyc.size() < exp_vcyc.size()) ? vcyc.size() : exp_vcyc.size();
      for (int i = 0; i < n; i++) begin
         check_cnt++; if (vdat[i] !== exp_vdat[i] || vcyc[i] !== exp_vcyc[i])
            $display("FAIL rand_frame_%0d: got %h at %0d want %h at %0d", i, vdat[i], vcyc[i], exp_vdat[i], exp_vcyc[i]); else pass_cnt++;
      end
      n = (ecyc.size() < exp_ecyc.size()) ? ecyc.size() : exp_ecyc.size();
      for (int i = 0; i < n; i++) begin
         check_cnt++; if (ecyc[i] !== exp_ecyc[i])
            $display("FAIL rand_err_%0d: got %0d want %0d", i, ecyc[i], exp_ecyc[i]); else pass_cnt++;
      end
      check_cnt++; if (rx_data !== model_data) $display("FAIL rand_hold: got %h want %h", rx_data, model_data); else pass_cnt++;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int c0;
      clear_mon();
      send_frame(8'h07, 1'b1, 1'b1, c0);
      wait_cyc(20);
      check_cnt++; if (vcyc.size() !== 1 || rx_data !== 8'h07)
         $display("FAIL parity_good: got %0d pulses data %h want 1 pulse data 07", vcyc.size(), rx_data); else pass_cnt++;
      send_frame(8'h5A, 1'b1, 1'b0, c0);
      wait_cyc(20);
      clear_mon();
      send_frame(8'h07, 1'b1, 1'b0, c0);
      wait_cyc(20);
      check_cnt++; if (ecyc.size() !== 1 || vcyc.size() !== 0)
         $display("FAIL parity_bad: got %0d err %0d valid want 1 and 0", ecyc.size(), vcyc.size()); else pass_cnt++;
      check_cnt++; if (rx_data !== 8'h5A) $display("FAIL parity_hold: got %h want 5a", rx_data); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL parity_idle: got %b want 0", busy); else pass_cnt++;
      model_data = 8'h5A;
   endtask
`endif

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_random();
      check_cnt++; if (both_cnt !== 0) $display("FAIL exclusive_strobes: got %0d overlaps want 0", both_cnt); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
